step_sequencer: RTL and testbench
=================================

# step_sequencer

Programmable step sequencer that drives the synth voice. Holds a table of up to NSTEPS steps, each with a frequency divider word, waveform select and gate bit. While playing, it advances one step every `tempo` clk cycles. Each step presents that step's divider word to the frequency divider, the waveform code to the waveform mux, and a timed gate to the output enable path.

## Interface
- NSTEPS, 8, number of table entries (power of two, ≥2)
- DIVW, 16, width of the divider word presented to the frequency divider
- TW, 24, width of tempo and gate-length counters
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- play  in  1  level; 1 = run, 0 = stop
- tempo  in  TW  clk cycles per step; 0 treated as 1
- gate_len  in  TW  clk cycles gate stays high within a step
- last_step  in  log2(NSTEPS)  index of final step before wrap
- wr_en  in  1  table write strobe
- wr_addr  in  log2(NSTEPS)  table write address
- wr_div  in  DIVW  divider word to store
- wr_wave  in  2  waveform code to store
- wr_gate  in  1  gate-enable bit to store
- div_val  out  DIVW  current step divider word
- wave_sel  out  2  current step waveform code
- gate  out  1  note gate
- step_idx  out  log2(NSTEPS)  current step index
- step_strobe  out  1  one-cycle pulse on each step load
- running  out  1  high while not IDLE

## Operation
- States: IDLE, NOTE (gate phase), REST (post-gate phase).
- IDLE:
  - All outputs at reset values. tick_cnt = 0.
  - play=1 → load step 0 next cycle, enter NOTE.
- Step load (IDLE→NOTE, or NOTE/REST at end of step):
  - Register div_val, wave_sel and step_idx from the table entry.
  - step_strobe=1 for that one cycle. tick_cnt ← 0.
- Gate: gate = entry gate bit AND (tick_cnt < gate_len).
  - NOTE→REST when tick_cnt reaches gate_len−1 (no REST if gate_len ≥ effective tempo).
  - gate_len = 0 → load directly into REST; gate never rises.
- End of step: tick_cnt ≥ effective tempo − 1 → load next step.
  - Next step = step_idx+1, or 0 when step_idx ≥ last_step. Wrap is unconditional.
  - Lowering last_step below step_idx wraps at the next end of step.
- Live inputs: tempo and gate_len are compared live every cycle; no latching.
  - If a tempo change makes tick_cnt ≥ new tempo−1, the step advances next cycle.
- play=0 in NOTE/REST:
  - Next cycle → IDLE: gate=0, running=0, step_idx=0, div_val=0, wave_sel=0.
  - No tail; the current step is abandoned.
- Table writes:
  - Accepted in any state, one per cycle, visible the following cycle.
  - A write to the entry being loaded in the same cycle: the load uses the pre-write contents.
  - Writes never alter outputs of the step already loaded.
- Table reset: all entries cleared (div 0, wave 0, gate 0).

## Timing
- Reset values: div_val=0, wave_sel=0, gate=0, step_idx=0, step_strobe=0, running=0; state IDLE.
- Reset mid-run returns to IDLE on the next edge and clears the table.
- All outputs are registered.
- Latency play↑ → step_strobe/running/first gate: 1 cycle.
- Step period: exactly max(tempo,1) cycles between consecutive step_strobe pulses.
- Gate high for min(gate_len, tempo) cycles, starting on the step_strobe cycle, when the entry gate bit = 1.
- play↓ → gate=0 and running=0: 1 cycle.
- play↑ again in the same cycle the machine enters IDLE is honoured on the following cycle.

## Structure
- Shared package synth_pkg:
  - Waveform code constants WAVE_SINE=0, WAVE_TRI=1, WAVE_SQR=2, WAVE_SAW=3.
  - Sequencer state enum.
  - Default DIVW and TW.
- Sub-module seq_step_ram:
  - NSTEPS×(DIVW+3) register file.
  - Synchronous clear on rst; one write port; combinational read port.
  - Read-before-write on the same address.
- Top level holds the FSM, tick_cnt and the step index/wrap logic.

## Test plan
- Reset, then write steps 0–3 with div 100/200/300/400, waves 0/1/2/3, gate 1. Set last_step=3, tempo=10, gate_len=6, play=1 → step_strobe at cycles 1, 11, 21, 31, 41. Step sequence 0,1,2,3,0. Gate high 6 cycles, low 4 per step.
- Step 2 gate bit=0 → gate stays 0 for the whole of step 2; div_val still 300.
- tempo=0 and gate_len=0 → step_strobe every cycle, gate never high, step_idx cycles 0..last_step.
- Write step 1 div=999 on the exact cycle step 1 loads → div_val=200 for that pass, 999 on the next pass.
- During step 2 at tick_cnt=7, change tempo 10→4 → advance on the next cycle. Subsequent steps last 4 cycles.
- play=0 mid-NOTE, then rst mid-run → IDLE outputs all zero within 1 cycle. After rst, the table reads zero: replay gives div_val=0 and gate=0.

Source files
------------

// File: rtl/step_sequencer_pkg.sv
// synth_pkg: shared waveform codes, sequencer state and default widths
package synth_pkg;
   localparam int DEF_NSTEPS = 8;
   localparam int DEF_DIVW   = 16;
   localparam int DEF_TW     = 24;
   localparam logic [1:0] WAVE_SINE = 2'd0;
   localparam logic [1:0] WAVE_TRI  = 2'd1;
   localparam logic [1:0] WAVE_SQR  = 2'd2;
   localparam logic [1:0] WAVE_SAW  = 2'd3;
   typedef enum logic [1:0] {SEQ_IDLE, SEQ_NOTE, SEQ_REST} seq_state_t;
endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: control, table-write and voice-output signals of the sequencer
interface step_sequencer_if import synth_pkg::*; #(
   parameter int NSTEPS = DEF_NSTEPS,
   parameter int DIVW   = DEF_DIVW,
   parameter int TW     = DEF_TW
);
   localparam int AW = $clog2(NSTEPS);
   logic            play;
   logic [TW-1:0]   tempo;
   logic [TW-1:0]   gate_len;
   logic [AW-1:0]   last_step;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DIVW-1:0] wr_div;
   logic [1:0]      wr_wave;
   logic            wr_gate;
   logic [DIVW-1:0] div_val;
   logic [1:0]      wave_sel;
   logic            gate;
   logic [AW-1:0]   step_idx;
   logic            step_strobe;
   logic            running;
   modport master (
      output play, tempo, gate_len, last_step, wr_en, wr_addr, wr_div, wr_wave, wr_gate,
      input  div_val, wave_sel, gate, step_idx, step_strobe, running
   );
   modport slave (
      input  play, tempo, gate_len, last_step, wr_en, wr_addr, wr_div, wr_wave, wr_gate,
      output div_val, wave_sel, gate, step_idx, step_strobe, running
   );
endinterface

// File: rtl/seq_step_ram.sv
// seq_step_ram: step table register file, one write port, combinational read-before-write
module seq_step_ram import synth_pkg::*; #(
   parameter int NSTEPS = DEF_NSTEPS,
   parameter int W      = DEF_DIVW + 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we,
   input  logic [$clog2(NSTEPS)-1:0] waddr,
   input  logic [W-1:0]              wdata,
   input  logic [$clog2(NSTEPS)-1:0] raddr,
   output logic [W-1:0]              rdata
);
   logic [W-1:0] mem [NSTEPS];
   // clear the whole table on reset, otherwise store one entry per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSTEPS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: plays the step table, one step every max(tempo,1) cycles with a timed gate
module step_sequencer import synth_pkg::*; #(
   parameter int NSTEPS = DEF_NSTEPS,
   parameter int DIVW   = DEF_DIVW,
   parameter int TW     = DEF_TW
) (
   input logic             clk,
   input logic             rst,
   step_sequencer_if.slave sb
);
   localparam int AW = $clog2(NSTEPS);
   localparam int EW = DIVW + 3;
   localparam logic [TW-1:0] ONE = TW'(1);
   seq_state_t      state, state_n;
   logic [TW-1:0]   tick_cnt, tick_n, tempo_eff;
   logic [AW-1:0]   rd_addr, nxt_idx, idx_n;
   logic [EW-1:0]   rd_data;
   logic [DIVW-1:0] div_n;
   logic [1:0]      wave_n;
   logic            load, end_step, gate_done, idle_n;
   logic            g_bit, g_bit_n, gate_n;
   assign tempo_eff = (sb.tempo == '0) ? ONE : sb.tempo;
   assign end_step  = tick_cnt >= tempo_eff - ONE;
   assign gate_done = ({1'b0, tick_cnt} + {1'b0, ONE}) >= {1'b0, sb.gate_len};
   assign nxt_idx   = (sb.step_idx >= sb.last_step) ? '0 : sb.step_idx + AW'(1);
   assign rd_addr   = (state == SEQ_IDLE) ? '0 : nxt_idx;
   seq_step_ram #(.NSTEPS(NSTEPS), .W(EW)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (sb.wr_en),
      .waddr (sb.wr_addr),
      .wdata ({sb.wr_gate, sb.wr_wave, sb.wr_div}),
      .raddr (rd_addr),
      .rdata (rd_data)
   );
   // state register
   always_ff @(posedge clk) begin
      state <= rst ? SEQ_IDLE : state_n;
   end
   // next state: stop wins, then step load, then the note-to-rest transition
   always_comb begin
      load    = sb.play && (state == SEQ_IDLE || end_step);
      state_n = !sb.play ? SEQ_IDLE
              : load ? ((sb.gate_len == '0) ? SEQ_REST : SEQ_NOTE)
              : (state == SEQ_NOTE && gate_done) ? SEQ_REST
              : state;
   end
   // next output values: zero in idle, table entry on load, otherwise hold
   always_comb begin
      idle_n  = state_n == SEQ_IDLE;
      tick_n  = (load || idle_n) ? '0 : tick_cnt + ONE;
      div_n   = idle_n ? '0 : load ? rd_data[DIVW-1:0] : sb.div_val;
      wave_n  = idle_n ? '0 : load ? rd_data[DIVW+1:DIVW] : sb.wave_sel;
      idx_n   = idle_n ? '0 : load ? rd_addr : sb.step_idx;
      g_bit_n = idle_n ? 1'b0 : load ? rd_data[EW-1] : g_bit;
      gate_n  = g_bit_n && state_n == SEQ_NOTE;
   end
   // registered outputs and step timer
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt       <= '0;
         g_bit          <= 1'b0;
         sb.div_val     <= '0;
         sb.wave_sel    <= '0;
         sb.step_idx    <= '0;
         sb.gate        <= 1'b0;
         sb.step_strobe <= 1'b0;
         sb.running     <= 1'b0;
      end else begin
         tick_cnt       <= tick_n;
         g_bit          <= g_bit_n;
         sb.div_val     <= div_n;
         sb.wave_sel    <= wave_n;
         sb.step_idx    <= idx_n;
         sb.gate        <= gate_n;
         sb.step_strobe <= load;
         sb.running     <= !idle_n;
      end
   end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: scoreboard bench, expected steps queued at stimulus and checked on each step_strobe
module tb_step_sequencer;
   import synth_pkg::*;
   typedef struct {
      int idx;
      int div;
      int wave;
      int per;
      int gon;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   exp_t cur;
   bit   pend;
   int   len, gc;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   step_sequencer_if sb();
   step_sequencer dut (.clk(clk), .rst(rst), .sb(sb));
   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask
   task automatic push(input int idx, input int div, input int wave, input int per, input int gon);
      exp_t e;
      e = '{idx, div, wave, per, gon};
      q.push_back(e);
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wr(input int a, input int d, input int w, input int g);
      sb.wr_en   = 1'b1;
      sb.wr_addr = 3'(a);
      sb.wr_div  = 16'(d);
      sb.wr_wave = 2'(w);
      sb.wr_gate = 1'(g);
      step(1);
      sb.wr_en = 1'b0;
   endtask
   task automatic idle_chk(input string tag);
      @(negedge clk);
      check({tag, "_gate"}, int'(sb.gate), 0);
      check({tag, "_running"}, int'(sb.running), 0);
      check({tag, "_strobe"}, int'(sb.step_strobe), 0);
      check({tag, "_idx"}, int'(sb.step_idx), 0);
      check({tag, "_div"}, int'(sb.div_val), 0);
      check({tag, "_wave"}, int'(sb.wave_sel), 0);
   endtask
   task automatic run(input int n, input string tag);
      step(1);
      sb.play = 1'b1;
      step(n);
      sb.play = 1'b0;
      step(1);
      idle_chk(tag);
      check({tag, "_drain"}, q.size(), 0);
   endtask
   // scoreboard monitor: on each strobe close out the previous step, then pop and compare the new one
   initial begin
      pend = 1'b0;
      len  = 0;
      gc   = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0;
         end else if (sb.step_strobe) begin
            if (pend && cur.per != 0) begin
               check("period", len, cur.per);
               check("gate_cycles", gc, cur.gon);
            end
            if (q.size() == 0) begin
               check("extra_strobe", 1, 0);
               pend = 1'b0;
            end else begin
               cur  = q.pop_front();
               pend = 1'b1;
               check("step_idx", int'(sb.step_idx), cur.idx);
               check("div_val", int'(sb.div_val), cur.div);
               check("wave_sel", int'(sb.wave_sel), cur.wave);
            end
            len = 1;
            gc  = int'(sb.gate);
         end else begin
            len++;
            gc += int'(sb.gate);
         end
      end
   end
   initial begin
      sb.play      = 1'b0;
      sb.tempo     = 24'd10;
      sb.gate_len  = 24'd6;
      sb.last_step = 3'd3;
      sb.wr_en     = 1'b0;
      sb.wr_addr   = '0;
      sb.wr_div    = '0;
      sb.wr_wave   = '0;
      sb.wr_gate   = 1'b0;
      step(3);
      rst = 1'b0;
      idle_chk("reset");
      wr(0, 100, int'(WAVE_SINE), 1);
      wr(1, 200, int'(WAVE_TRI), 1);
      wr(2, 300, int'(WAVE_SQR), 1);
      wr(3, 400, int'(WAVE_SAW), 1);
      // basic four-step loop with wrap back to step 0
      for (int i = 0; i < 5; i++) push(i % 4, 100 * (i % 4 + 1), i % 4, (i < 4) ? 10 : 0, 6);
      sb.play = 1'b1;
      step(1);
      @(negedge clk);
      check("lat_strobe", int'(sb.step_strobe), 1);
      check("lat_running", int'(sb.running), 1);
      check("lat_gate", int'(sb.gate), 1);
      step(40);
      sb.play = 1'b0;
      step(1);
      idle_chk("stop1");
      check("drain1", q.size(), 0);
      // step 2 with gate bit cleared
      wr(2, 300, int'(WAVE_SQR), 0);
      push(0, 100, 0, 10, 6);
      push(1, 200, 1, 10, 6);
      push(2, 300, 2, 10, 0);
      push(3, 400, 3, 0, 0);
      run(31, "s2");
      // zero tempo and zero gate length: a step every cycle, never gated
      sb.tempo     = 24'd0;
      sb.gate_len  = 24'd0;
      sb.last_step = 3'd2;
      for (int i = 0; i < 7; i++) push(i % 3, 100 * (i % 3 + 1), i % 3, (i < 6) ? 1 : 0, 0);
      run(7, "s3");
      // write to step 1 in the cycle it loads
      sb.tempo     = 24'd10;
      sb.gate_len  = 24'd6;
      sb.last_step = 3'd3;
      push(0, 100, 0, 10, 6);
      push(1, 200, 1, 10, 6);
      push(2, 300, 2, 10, 0);
      push(3, 400, 3, 10, 6);
      push(0, 100, 0, 10, 6);
      push(1, 999, 1, 0, 0);
      step(1);
      sb.play = 1'b1;
      step(10);
      wr(1, 999, 1, 1);
      step(40);
      sb.play = 1'b0;
      step(1);
      idle_chk("s4");
      check("s4_drain", q.size(), 0);
      // tempo shortened at tick 7 of step 2
      wr(2, 300, int'(WAVE_SQR), 1);
      push(0, 100, 0, 10, 6);
      push(1, 999, 1, 10, 6);
      push(2, 300, 2, 8, 6);
      push(3, 400, 3, 4, 4);
      push(0, 100, 0, 4, 4);
      push(1, 999, 1, 0, 0);
      step(1);
      sb.play = 1'b1;
      step(28);
      sb.tempo = 24'd4;
      step(9);
      sb.play = 1'b0;
      step(1);
      idle_chk("s5");
      check("s5_drain", q.size(), 0);
      sb.tempo = 24'd10;
      // stop mid-note, immediate restart, then reset mid-run
      push(0, 100, 0, 0, 0);
      step(1);
      sb.play = 1'b1;
      step(3);
      @(negedge clk);
      check("mid_note_gate", int'(sb.gate), 1);
      sb.play = 1'b0;
      step(1);
      sb.play = 1'b1;
      @(negedge clk);
      check("stop_running", int'(sb.running), 0);
      check("stop_gate", int'(sb.gate), 0);
      check("stop_div", int'(sb.div_val), 0);
      push(0, 100, 0, 0, 0);
      step(1);
      @(negedge clk);
      check("restart_strobe", int'(sb.step_strobe), 1);
      check("restart_running", int'(sb.running), 1);
      step(3);
      rst     = 1'b1;
      sb.play = 1'b0;
      step(1);
      idle_chk("rst_mid");
      rst = 1'b0;
      push(0, 0, 0, 10, 0);
      push(1, 0, 0, 10, 0);
      push(2, 0, 0, 0, 0);
      run(21, "cleared");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
